fft_reorder: RTL and testbench
==============================

FFT_REORDER -- requirements
Module: fft_reorder

Interface
REQ-001 Parameter TOTAL_STAGE, default 10: log2 of frame length N; N = 2**TOTAL_STAGE.
REQ-002 Parameter REAL_WIDTH, default 16: width of the real part.
REQ-003 Parameter IMGN_WIDTH, default 16: width of the imaginary part.
REQ-004 Parameter BITREV, default 0: 1 means the write address is bit-reverse(iaddr); 0 means the write address is iaddr.
REQ-005 Port iclk, input, 1: the single clock; all logic is rising-edge.
REQ-006 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 Port ien, input, 1: FFT result sample valid, one sample per cycle.
REQ-008 Port iaddr, input, TOTAL_STAGE: bin index of the input sample.
REQ-009 Port iReal, input, REAL_WIDTH: real part of the input sample.
REQ-010 Port iImag, input, IMGN_WIDTH: imaginary part of the input sample.
REQ-011 Port oen, output, 1: output sample valid.
REQ-012 Port oready, input, 1: downstream accepts the sample.
REQ-013 Port oaddr, output, TOTAL_STAGE: natural-order bin index of the output sample.
REQ-014 Port oReal, output, REAL_WIDTH: real part of the output sample.
REQ-015 Port oImag, output, IMGN_WIDTH: imaginary part of the output sample.
REQ-016 Port olast, output, 1: asserted together with oen when oaddr = N-1.
REQ-017 Port oovf, output, 1: sticky flag; a sample was dropped.

Function
REQ-018 The block SHALL hold two N-entry banks (ping-pong), each with state FREE, FILLING or FULL, plus a write-bank pointer.
REQ-019 Write side: each ien cycle whose write bank is writable SHALL store {iReal, iImag} at the write address and increment a write counter.
REQ-020 The sample that brings the write count to N SHALL mark the bank FULL, clear the counter and toggle the write-bank pointer, all in the same cycle.
REQ-021 A bank SHALL count as writable when it is FREE/FILLING, or when it is being freed by the final read handshake in the same cycle.
REQ-022 An ien arriving when the write bank is not writable SHALL be dropped, SHALL leave the counter unchanged, and SHALL set oovf, which stays set until reset.
REQ-023 Gaps in ien SHALL be allowed; frame completion is determined by the count, not by address order, and duplicate addresses overwrite.
REQ-024 Read FSM states SHALL be IDLE, FETCH and STREAM.
REQ-025 IDLE -> FETCH when the oldest FULL bank exists; FETCH issues the RAM read of address 0 and then goes to STREAM.
REQ-026 In STREAM, oen=1 and oaddr is the read index; on oen&&oready the index SHALL advance and the RAM read of the next address SHALL be issued in the same cycle.
REQ-027 While oen=1 and oready=0, oaddr/oReal/oImag/olast SHALL hold stable.
REQ-028 On the handshake with olast=1, the bank SHALL become FREE. If the other bank is FULL, address 0 of that bank is read in the same cycle and the FSM stays in STREAM (no gap); otherwise the FSM goes to IDLE.
REQ-029 Latency: the first oen of a frame SHALL occur 2 cycles after the cycle that writes its N-th sample, when the read side is IDLE.
REQ-030 Continuous ien at 1 sample/cycle with oready held at 1 SHALL be sustained indefinitely with no drops.
REQ-031 Frames SHALL be output in the order they were completed.

Reset
REQ-032 While rst_n=0: oen=0, olast=0, oovf=0, oaddr=0, oReal=0, oImag=0; both banks FREE; write pointer and counter 0; FSM in IDLE.
REQ-033 Reset asserted mid-frame SHALL discard all partial and full frames; RAM contents need not be cleared.

Structure
REQ-034 TOTAL_STAGE, REAL_WIDTH and IMGN_WIDTH defaults, CPLX_WIDTH, the bank-state enum and the read-FSM state enum SHALL live in the shared FFT package/include.
REQ-035 Storage SHALL be one sub-module, fft_reorder_ram: a simple dual-port RAM of 2N x CPLX_WIDTH with a registered read and read-enable; the bank bit is the address MSB.

Verification (TOTAL_STAGE=4, N=16)
REQ-036 BITREV=0, oready=1, iaddr 0..15 with data k+j(-k) -> oen 2 cycles after the last write; oaddr 0..15 with matching data; olast only at oaddr=15.
REQ-037 BITREV=1, iaddr 0..15 sequential, data real=k -> output oaddr m carries real = bit-reverse(m), e.g. oaddr 1 gives 8.
REQ-038 4 frames back-to-back continuous, oready=1 -> 64 outputs with no oen gap after the first frame, oovf=0.
REQ-039 oready=0 throughout, 3 frames input -> frames 1-2 are stored, all 16 samples of frame 3 are dropped, oovf=1; after oready=1, frames 1 then 2 are output intact.
REQ-040 oready toggling randomly -> outputs stable while stalled, ordering and data are correct.
REQ-041 Reset pulse after 7 writes of a frame -> no output; the next full frame is output correctly starting at oaddr 0.

Source files
------------

// File: rtl/fft_reorder_pkg.sv
// -----------------------------------------------------------------------------
// fft_reorder_pkg
// Shared definitions for the FFT output reorder buffer: default frame size and
// sample widths, the packed complex width, the per-bank occupancy state and
// the read-side FSM state.
// -----------------------------------------------------------------------------
package fft_reorder_pkg;

  localparam int TOTAL_STAGE_DEF = 10;
  localparam int REAL_WIDTH_DEF  = 16;
  localparam int IMGN_WIDTH_DEF  = 16;
  localparam int CPLX_WIDTH      = REAL_WIDTH_DEF + IMGN_WIDTH_DEF;

  // Occupancy of one ping-pong bank.
  typedef enum logic [1:0] {
    BANK_FREE    = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_t;

  // Read-side sequencer.
  typedef enum logic [1:0] {
    RD_IDLE   = 2'd0,
    RD_FETCH  = 2'd1,
    RD_STREAM = 2'd2
  } rd_state_t;

endpackage

// File: rtl/fft_reorder_ram.sv
// -----------------------------------------------------------------------------
// fft_reorder_ram
// Simple dual-port RAM holding both ping-pong banks. The bank select is the
// address MSB. Reads are registered and only update when i_re is high, so the
// read data holds while the consumer stalls.
//
// Ports:
//   iclk     : clock, rising edge
//   rst_n    : async active-low reset (read data register only)
//   i_we     : write enable
//   i_waddr  : write address {bank, index}
//   i_wdata  : write data
//   i_re     : read enable
//   i_raddr  : read address {bank, index}
//   o_rdata  : registered read data
// -----------------------------------------------------------------------------
module fft_reorder_ram
  import fft_reorder_pkg::*;
#(
  parameter int AW = TOTAL_STAGE_DEF + 1,
  parameter int DW = CPLX_WIDTH
) (
  input  logic          iclk,
  input  logic          rst_n,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [2**AW];
  logic [DW-1:0] r_rdata;

  // Storage array is not reset; contents are don't-care after reset.
  always_ff @(posedge iclk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_ff @(posedge iclk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/fft_reorder.sv
// -----------------------------------------------------------------------------
// fft_reorder
// Ping-pong reorder buffer for FFT results. Samples arrive with their bin
// index (optionally bit-reversed on write) and are streamed out frame by
// frame in natural bin order with a valid/ready handshake.
//
// Ports:
//   iclk   : clock, rising edge
//   rst_n  : async active-low reset
//   ien    : input sample valid
//   iaddr  : input bin index
//   iReal  : input real part
//   iImag  : input imaginary part
//   oen    : output sample valid
//   oready : downstream ready
//   oaddr  : output natural-order bin index
//   oReal  : output real part
//   oImag  : output imaginary part
//   olast  : last bin of the frame (with oen)
//   oovf   : sticky overflow, a sample was dropped
//
// Read FSM:
//   state     | meaning
//   RD_IDLE   | no frame being output, waiting for a full bank
//   RD_FETCH  | RAM read of index 0 in flight
//   RD_STREAM | oen high, advancing one index per handshake
// -----------------------------------------------------------------------------
module fft_reorder
  import fft_reorder_pkg::*;
#(
  parameter int TOTAL_STAGE = TOTAL_STAGE_DEF,
  parameter int REAL_WIDTH  = REAL_WIDTH_DEF,
  parameter int IMGN_WIDTH  = IMGN_WIDTH_DEF,
  parameter bit BITREV      = 1'b0
) (
  input  logic                   iclk,
  input  logic                   rst_n,
  input  logic                   ien,
  input  logic [TOTAL_STAGE-1:0] iaddr,
  input  logic [REAL_WIDTH-1:0]  iReal,
  input  logic [IMGN_WIDTH-1:0]  iImag,
  output logic                   oen,
  input  logic                   oready,
  output logic [TOTAL_STAGE-1:0] oaddr,
  output logic [REAL_WIDTH-1:0]  oReal,
  output logic [IMGN_WIDTH-1:0]  oImag,
  output logic                   olast,
  output logic                   oovf
);

  localparam int CW = REAL_WIDTH + IMGN_WIDTH;
  localparam logic [TOTAL_STAGE-1:0] LAST_IDX = '1;
  localparam logic [TOTAL_STAGE-1:0] PENULT   = LAST_IDX - 1'b1;

  // Write side
  bank_state_t            r_bank_st [2];
  logic                   r_wr_bank;
  logic [TOTAL_STAGE-1:0] r_wr_cnt;
  logic                   r_ovf;

  // Read side
  rd_state_t              r_rd_state;
  logic                   r_rd_bank;
  logic                   r_oen;
  logic [TOTAL_STAGE-1:0] r_oaddr;
  logic                   r_olast;

  logic [TOTAL_STAGE-1:0] w_wr_idx;
  logic                   w_rd_free;
  logic                   w_writable;
  logic                   w_wr_en;
  logic                   w_fill_done;
  logic                   w_next_full;
  logic                   w_start;

  logic                   w_rd_en;
  logic                   w_rd_bank_sel;
  logic [TOTAL_STAGE-1:0] w_rd_idx;
  logic [CW-1:0]          w_rdata;

  generate
    if (BITREV) begin : g_brev
      for (genvar i = 0; i < TOTAL_STAGE; i++) begin : g_bit
        assign w_wr_idx[i] = iaddr[TOTAL_STAGE-1-i];
      end
    end else begin : g_nat
      assign w_wr_idx = iaddr;
    end
  endgenerate

  // Final handshake of a frame releases its bank this cycle.
  assign w_rd_free   = (r_rd_state == RD_STREAM) && oready && r_olast;
  // A full bank that is being released right now can already take the next
  // frame's first sample; this is what keeps 1 sample/cycle drop-free.
  assign w_writable  = (r_bank_st[r_wr_bank] != BANK_FULL) ||
                       (w_rd_free && (r_rd_bank == r_wr_bank));
  assign w_wr_en     = ien && w_writable;
  assign w_fill_done = w_wr_en && (r_wr_cnt == LAST_IDX);
  assign w_next_full = (r_bank_st[~r_rd_bank] == BANK_FULL);
  // Banks fill and drain in the same alternating order, so the oldest full
  // bank is always the one the read pointer names. Looking at the completing
  // write directly saves a cycle of first-sample latency.
  assign w_start     = (r_bank_st[r_rd_bank] == BANK_FULL) ||
                       (w_fill_done && (r_wr_bank == r_rd_bank));

  always_ff @(posedge iclk or negedge rst_n) begin
    if (!rst_n) begin
      r_bank_st[0] <= BANK_FREE;
      r_bank_st[1] <= BANK_FREE;
      r_wr_bank    <= 1'b0;
      r_wr_cnt     <= '0;
      r_ovf        <= 1'b0;
    end else begin
      if (ien && !w_writable) begin
        r_ovf <= 1'b1;
      end
      if (w_rd_free) begin
        r_bank_st[r_rd_bank] <= BANK_FREE;
      end
      // Placed after the release so a write to the released bank wins.
      if (w_wr_en) begin
        if (w_fill_done) begin
          r_bank_st[r_wr_bank] <= BANK_FULL;
          r_wr_cnt             <= '0;
          r_wr_bank            <= ~r_wr_bank;
        end else begin
          r_bank_st[r_wr_bank] <= BANK_FILLING;
          r_wr_cnt             <= r_wr_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge iclk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_state <= RD_IDLE;
      r_rd_bank  <= 1'b0;
      r_oen      <= 1'b0;
      r_oaddr    <= '0;
      r_olast    <= 1'b0;
    end else begin
      case (r_rd_state)
        RD_IDLE: begin
          if (w_start) begin
            r_rd_state <= RD_FETCH;
          end
        end
        RD_FETCH: begin
          r_rd_state <= RD_STREAM;
          r_oen      <= 1'b1;
          r_oaddr    <= '0;
          r_olast    <= 1'b0;
        end
        RD_STREAM: begin
          if (oready) begin
            if (r_olast) begin
              r_rd_bank <= ~r_rd_bank;
              r_oaddr   <= '0;
              r_olast   <= 1'b0;
              if (!w_next_full) begin
                r_rd_state <= RD_IDLE;
                r_oen      <= 1'b0;
              end
            end else begin
              r_oaddr <= r_oaddr + 1'b1;
              r_olast <= (r_oaddr == PENULT);
            end
          end
        end
        default: begin
          r_rd_state <= RD_IDLE;
          r_oen      <= 1'b0;
          r_olast    <= 1'b0;
        end
      endcase
    end
  end

  // RAM read issue mirrors the FSM transitions above: the read for the index
  // that will be presented next is launched on the same edge.
  always_comb begin
    w_rd_en       = 1'b0;
    w_rd_bank_sel = r_rd_bank;
    w_rd_idx      = '0;
    case (r_rd_state)
      RD_FETCH: begin
        w_rd_en = 1'b1;
      end
      RD_STREAM: begin
        if (oready) begin
          if (r_olast) begin
            w_rd_en       = w_next_full;
            w_rd_bank_sel = ~r_rd_bank;
          end else begin
            w_rd_en  = 1'b1;
            w_rd_idx = r_oaddr + 1'b1;
          end
        end
      end
      default: begin
        w_rd_en = 1'b0;
      end
    endcase
  end

  fft_reorder_ram #(
    .AW (TOTAL_STAGE + 1),
    .DW (CW)
  ) u_ram (
    .iclk    (iclk),
    .rst_n   (rst_n),
    .i_we    (w_wr_en),
    .i_waddr ({r_wr_bank, w_wr_idx}),
    .i_wdata ({iReal, iImag}),
    .i_re    (w_rd_en),
    .i_raddr ({w_rd_bank_sel, w_rd_idx}),
    .o_rdata (w_rdata)
  );

  assign oen   = r_oen;
  assign oaddr = r_oaddr;
  assign olast = r_olast;
  assign oovf  = r_ovf;
  assign oReal = w_rdata[CW-1:IMGN_WIDTH];
  assign oImag = w_rdata[IMGN_WIDTH-1:0];

endmodule

// File: tb/tb_fft_reorder.sv
// -----------------------------------------------------------------------------
// tb_fft_reorder
// Directed bench for fft_reorder with N = 16. Two instances share stimulus:
// u_nat (natural write order) and u_rev (bit-reversed write order).
// -----------------------------------------------------------------------------
module tb_fft_reorder;

  logic iclk = 1'b0;
  always #5 iclk = ~iclk;

  logic        rst_n;
  logic        ien;
  logic [3:0]  iaddr;
  logic [15:0] iReal;
  logic [15:0] iImag;
  logic        oready;

  logic        oen,  olast,  oovf;
  logic [3:0]  oaddr;
  logic [15:0] oReal, oImag;

  logic        oen1, olast1, oovf1;
  logic [3:0]  oaddr1;
  logic [15:0] oReal1, oImag1;

  int n_checks = 0;
  int n_errors = 0;

  fft_reorder #(.TOTAL_STAGE(4), .REAL_WIDTH(16), .IMGN_WIDTH(16), .BITREV(1'b0)) u_nat (
    .iclk(iclk), .rst_n(rst_n), .ien(ien), .iaddr(iaddr), .iReal(iReal), .iImag(iImag),
    .oen(oen), .oready(oready), .oaddr(oaddr), .oReal(oReal), .oImag(oImag),
    .olast(olast), .oovf(oovf)
  );

  fft_reorder #(.TOTAL_STAGE(4), .REAL_WIDTH(16), .IMGN_WIDTH(16), .BITREV(1'b1)) u_rev (
    .iclk(iclk), .rst_n(rst_n), .ien(ien), .iaddr(iaddr), .iReal(iReal), .iImag(iImag),
    .oen(oen1), .oready(oready), .oaddr(oaddr1), .oReal(oReal1), .oImag(oImag1),
    .olast(olast1), .oovf(oovf1)
  );

  typedef struct {
    logic [3:0]  addr;
    logic [15:0] re;
    logic [15:0] im;
    logic        last;
    logic [15:0] re_rev;
  } vec_t;

  vec_t tbl [16];
  int   brev_tab [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Sample k of a run: real = base+k, imag = -(base+k), bin = k mod 16.
  task automatic send(input int base, input int nsamp);
    logic [15:0] v;
    for (int k = 0; k < nsamp; k++) begin
      @(negedge iclk);
      v     = 16'(base + k);
      ien   = 1'b1;
      iaddr = 4'(k);
      iReal = v;
      iImag = -v;
    end
    @(negedge iclk);
    ien = 1'b0;
  endtask

  task automatic recv(input int base, input int nout, input bit rnd, input bit nogap,
                      input string tag);
    int          n;
    int          cyc;
    bit          started;
    bit          stall;
    bit          rd;
    logic [15:0] v;
    logic [15:0] vi;
    logic [3:0]  p_addr;
    logic [15:0] p_re, p_im;
    logic        p_last;
    n = 0; cyc = 0; started = 0; stall = 0;
    p_addr = '0; p_re = '0; p_im = '0; p_last = 1'b0;
    while (n < nout && cyc < 3000) begin
      @(negedge iclk);
      cyc++;
      if (stall) begin
        chk({tag, "_hold_oen"},  oen,   1);
        chk({tag, "_hold_addr"}, oaddr, p_addr);
        chk({tag, "_hold_re"},   oReal, p_re);
        chk({tag, "_hold_im"},   oImag, p_im);
        chk({tag, "_hold_last"}, olast, p_last);
      end
      if (nogap && started) chk({tag, "_nogap"}, oen, 1);
      rd     = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      oready = rd;
      if (oen) begin
        started = 1;
        if (rd) begin
          v  = 16'(base + n);
          vi = -v;
          chk({tag, "_addr"}, oaddr, n % 16);
          chk({tag, "_re"},   oReal, v);
          chk({tag, "_im"},   oImag, vi);
          chk({tag, "_last"}, olast, (n % 16) == 15);
          n++;
          stall = 0;
        end else begin
          stall  = 1;
          p_addr = oaddr; p_re = oReal; p_im = oImag; p_last = olast;
        end
      end else begin
        stall = 0;
      end
    end
    if (n < nout) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_timeout: got %0d outputs, expected %0d", tag, n, nout);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    logic [15:0] v;

    for (int m = 0; m < 16; m++) begin
      tbl[m].addr   = 4'(m);
      tbl[m].re     = 16'(m);
      tbl[m].im     = 16'(-m);
      tbl[m].last   = (m == 15);
      tbl[m].re_rev = 16'(brev_tab[m]);
    end

    // Reset state
    rst_n = 1'b0; ien = 1'b0; iaddr = '0; iReal = '0; iImag = '0; oready = 1'b1;
    repeat (3) @(negedge iclk);
    chk("rst_oen",   oen,   0);
    chk("rst_olast", olast, 0);
    chk("rst_oovf",  oovf,  0);
    chk("rst_oaddr", oaddr, 0);
    chk("rst_oreal", oReal, 0);
    chk("rst_oimag", oImag, 0);
    chk("rst_rev_oen", oen1, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge iclk);

    // Single frame: latency, natural order, olast, bit-reversed variant
    for (int k = 0; k < 16; k++) begin
      @(negedge iclk);
      v = 16'(k);
      ien = 1'b1; iaddr = 4'(k); iReal = v; iImag = -v;
    end
    @(negedge iclk);
    ien = 1'b0;
    chk("a_lat1_oen", oen, 0);
    @(negedge iclk);
    chk("a_lat2_oen", oen, 1);
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge iclk);
      chk("a_oen",    oen,    1);
      chk("a_addr",   oaddr,  tbl[i].addr);
      chk("a_re",     oReal,  tbl[i].re);
      chk("a_im",     oImag,  tbl[i].im);
      chk("a_last",   olast,  tbl[i].last);
      chk("a_rev_oen",  oen1,   1);
      chk("a_rev_addr", oaddr1, tbl[i].addr);
      chk("a_rev_re",   oReal1, tbl[i].re_rev);
    end
    @(negedge iclk);
    chk("a_end_oen", oen, 0);

    // Four back-to-back frames at full rate
    fork
      send(16'h0040, 64);
      recv(16'h0040, 64, 1'b0, 1'b1, "b");
    join
    chk("b_oovf", oovf, 0);
    repeat (5) @(negedge iclk);

    // Stalled consumer: third frame is dropped, first two survive
    oready = 1'b0;
    send(16'h0100, 48);
    chk("c_oovf",      oovf,  1);
    chk("c_stall_oen", oen,   1);
    chk("c_stall_addr", oaddr, 0);
    chk("c_stall_re",  oReal, 16'h0100);
    recv(16'h0100, 32, 1'b0, 1'b0, "c");
    seen = 0;
    repeat (20) begin
      @(negedge iclk);
      if (oen) seen = 1;
    end
    chk("c_no_frame3", seen, 0);
    chk("c_oovf_sticky", oovf, 1);

    // Reset in the middle of a frame
    oready = 1'b1;
    send(16'h0300, 7);
    @(negedge iclk);
    rst_n = 1'b0;
    #1;
    chk("e_rst_oen",   oen,   0);
    chk("e_rst_oovf",  oovf,  0);
    chk("e_rst_oaddr", oaddr, 0);
    chk("e_rst_oreal", oReal, 0);
    chk("e_rst_oimag", oImag, 0);
    chk("e_rst_olast", olast, 0);
    @(negedge iclk);
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge iclk);
      if (oen) seen = 1;
    end
    chk("e_no_partial", seen, 0);
    fork
      send(16'h0500, 16);
      recv(16'h0500, 16, 1'b0, 1'b0, "e");
    join
    repeat (5) @(negedge iclk);

    // Random backpressure across two frames
    fork
      send(16'h0600, 32);
      recv(16'h0600, 32, 1'b1, 1'b0, "d");
    join
    chk("d_oovf", oovf, 0);
    oready = 1'b1;
    repeat (5) @(negedge iclk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
